serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial two's-complement adder, the inverse companion of the 8-bit combinational subtractor: given a difference F = A − B and the subtrahend B, it reconstructs A = F + B, and serves as a general low-area adder where one result per WIDTH+1 cycles is acceptable. Operands are latched on a start handshake, summed LSB-first through a single full-adder cell and a carry flip-flop, and presented in parallel with carry-out and signed overflow on a one-cycle done pulse.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  first operand, latched when start is accepted
- b  input  WIDTH  second operand, latched when start is accepted
- cin  input  1  carry-in, latched when start is accepted
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse: sum, cout and overflow are valid
- sum  output  WIDTH  result, (a + b + cin) mod 2^WIDTH
- cout  output  1  unsigned carry out of the MSB
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. If start=1, latch a, b into shift registers, carry ← cin, bit counter ← 0, and go to SHIFT.
- SHIFT: busy=1. Each cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry; carry ← majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by one. Shift s into the result register at the MSB.
  - Counter increments.
  - On the MSB cycle (counter = WIDTH−1), capture overflow ← carry_in_to_msb ^ carry_out, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle. sum/cout/overflow are already final. Next state is IDLE; if start=1 in DONE, it is accepted as in IDLE (back-to-back operation).
- start while in SHIFT is ignored and not queued. Operand input changes during SHIFT have no effect.
- sum, cout and overflow hold their values after DONE until the next accepted start. During SHIFT, sum is partial and not valid.
- Reset (async, any state): state=IDLE. busy, done, sum, cout, overflow, counter, carry and shift registers all go to 0. Reset mid-operation aborts it with no done pulse.
- Arithmetic is modulo 2^WIDTH. cout and overflow are independent flags: unsigned and signed interpretation respectively.

## Timing
- start is sampled at edge k. SHIFT occupies the cycles after edges k+1 … k+WIDTH, with busy high during them. done is high in the cycle after edge k+WIDTH+1.
- Latency from accepted start to done: WIDTH+1 clocks (9 for WIDTH=8). Throughput with back-to-back starts: one result per WIDTH+1 clocks.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rst_n assertion takes effect immediately. Release is synchronised by the system; the first start is accepted on the first clock edge after release.

## Structure
- Shared package holds:
  - the state enum (IDLE, SHIFT, DONE)
  - the default width constant (8)
  - the counter width, derived as clog2(WIDTH)
- One sub-module: full_adder_bit (a, b, cin → s, cout), purely combinational, instantiated once in the datapath.
- The top level holds the FSM, counter, operand shift registers, result shift register and flag registers.

## Test plan
- a=0x35, b=0x12, cin=0, start pulse → done exactly 9 clocks later; sum=0x47, cout=0, overflow=0; busy high for the 8 preceding cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, overflow=1. Then a=0x80, b=0x80, cin=1 → sum=0x01, cout=1, overflow=1.
- Reconstruction: subtractor result 0x10−0x30=0xE0; feed a=0xE0, b=0x30, cin=0 → sum=0x10, cout=1, overflow=0.
- Hold start high continuously, changing a/b mid-operation → only operands sampled at acceptance are used; start is ignored in SHIFT; a new operation is accepted in the DONE cycle; done pulses every 9 clocks.
- Assert rst_n=0 at the 4th SHIFT cycle → all outputs 0 immediately, no done pulse. After release, a=0x01, b=0x02 → sum=0x03 with normal latency.
- Randomised sweep, ≥1000 operand/cin triples at WIDTH=8 plus a WIDTH=16 build → sum, cout and overflow match a reference model; done is never asserted without a prior accepted start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-counter width; a 1-bit floor keeps tiny widths legal.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_adder_if.sv
// Start/operand request and registered result bundle of the serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );

endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder cell shared by every bit position of the serial datapath.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: LSB-first through one full-adder cell,
// result presented in parallel with carry-out and signed overflow on a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_cout;
  logic             msb_cycle;

  full_adder_bit u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign msb_cycle = (cnt_q == CNT_W'(WIDTH - 1));

  // Next state and datapath; busy/done trail the state by one register stage.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = (state_q == SHIFT);
    done_d  = (state_q == DONE);

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (msb_cycle) begin
          // carry_q is the carry into the MSB on this cycle
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = res_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(16)) if16 ();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [15:0] a,
                       input logic [15:0] b, input logic ci);
    if (w == 8) begin
      if8.start = s;
      if8.a     = a[7:0];
      if8.b     = b[7:0];
      if8.cin   = ci;
    end else begin
      if16.start = s;
      if16.a     = a;
      if16.b     = b;
      if16.cin   = ci;
    end
  endtask

  function automatic logic o_busy(input int w);
    return (w == 8) ? if8.busy : if16.busy;
  endfunction
  function automatic logic o_done(input int w);
    return (w == 8) ? if8.done : if16.done;
  endfunction
  function automatic logic [15:0] o_sum(input int w);
    return (w == 8) ? 16'(if8.sum) : if16.sum;
  endfunction
  function automatic logic o_cout(input int w);
    return (w == 8) ? if8.cout : if16.cout;
  endfunction
  function automatic logic o_ovf(input int w);
    return (w == 8) ? if8.overflow : if16.overflow;
  endfunction

  // One isolated addition from IDLE: exact busy/done timing plus model result.
  task automatic run_op(input int w, input logic [15:0] a_in, input logic [15:0] b_in,
                        input logic ci);
    logic [15:0] mask;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] full;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
    int          msb;
    msb      = w - 1;
    mask     = (w == 8) ? 16'h00FF : 16'hFFFF;
    a        = a_in & mask;
    b        = b_in & mask;
    full     = 17'(a) + 17'(b) + 17'(ci);
    exp_sum  = full[15:0] & mask;
    exp_cout = (w == 8) ? full[8] : full[16];
    exp_ovf  = (a[msb] == b[msb]) && (exp_sum[msb] != a[msb]);

    drive(w, 1'b1, a, b, ci);
    @(posedge clk);
    #1;
    drive(w, 1'b0, ~a, ~b, ~ci);
    check("busy_after_accept", 32'(o_busy(w)), 32'd0);
    for (int i = 1; i <= w + 1; i++) begin
      @(posedge clk);
      #1;
      check("busy_timing", 32'(o_busy(w)), 32'(i <= w));
      check("done_timing", 32'(o_done(w)), 32'(i == w + 1));
    end
    check("sum", 32'(o_sum(w)), 32'(exp_sum));
    check("cout", 32'(o_cout(w)), 32'(exp_cout));
    check("overflow", 32'(o_ovf(w)), 32'(exp_ovf));
  endtask

  initial begin
    logic [7:0] ba [4];
    logic [7:0] bb [4];
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0);

    #1;
    check("rst_busy", 32'(if8.busy), 32'd0);
    check("rst_done", 32'(if8.done), 32'd0);
    check("rst_sum", 32'(if8.sum), 32'd0);
    check("rst_cout", 32'(if8.cout), 32'd0);
    check("rst_ovf", 32'(if8.overflow), 32'd0);
    check("rst_sum16", 32'(if16.sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including subtractor reconstruction 0x10-0x30=0xE0.
    run_op(8, 16'h35, 16'h12, 1'b0);
    check("sum_35_12", 32'(if8.sum), 32'h47);
    run_op(8, 16'hFF, 16'h01, 1'b0);
    check("cout_ff_01", 32'(if8.cout), 32'd1);
    run_op(8, 16'h7F, 16'h01, 1'b0);
    check("ovf_7f_01", 32'(if8.overflow), 32'd1);
    run_op(8, 16'h80, 16'h80, 1'b1);
    check("sum_80_80_1", 32'(if8.sum), 32'h01);
    run_op(8, 16'hE0, 16'h30, 1'b0);
    check("reconstruct", 32'(if8.sum), 32'h10);
    run_op(16, 16'h7FFF, 16'h0001, 1'b0);

    // Back-to-back with start held high and operands scrambled during SHIFT.
    ba = '{8'h35, 8'hFF, 8'h7F, 8'h80};
    bb = '{8'h12, 8'h01, 8'h01, 8'h80};
    @(negedge clk);
    drive(8, 1'b1, 16'(ba[0]), 16'(bb[0]), 1'b0);
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      #1;
      drive(8, (j < 3), 16'hA5, 16'h5A, 1'b1);
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk);
        #1;
        check("b2b_busy", 32'(if8.busy), 32'd1);
        check("b2b_done", 32'(if8.done), 32'd0);
        if (i == 8 && j < 3) drive(8, 1'b1, 16'(ba[j+1]), 16'(bb[j+1]), 1'b0);
      end
      @(posedge clk);
      #1;
      check("b2b_done_pulse", 32'(if8.done), 32'd1);
      check("b2b_sum", 32'(if8.sum), 32'(8'(ba[j] + bb[j])));
      if (j < 3) begin
        #0;
      end else begin
        @(posedge clk);
      end
    end

    // Reset during the 4th SHIFT cycle aborts the operation.
    @(negedge clk);
    drive(8, 1'b1, 16'h5A, 16'h3C, 1'b1);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(if8.busy), 32'd0);
    check("abort_done", 32'(if8.done), 32'd0);
    check("abort_sum", 32'(if8.sum), 32'd0);
    check("abort_cout", 32'(if8.cout), 32'd0);
    check("abort_ovf", 32'(if8.overflow), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(if8.done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8, 16'h01, 16'h02, 1'b0);
    check("post_reset_sum", 32'(if8.sum), 32'h03);

    // Randomised sweep at both widths.
    for (int n = 0; n < 1000; n++) begin
      run_op(8, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 200; n++) begin
      run_op(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
